// File: rtl/capture_buffer.sv
// capture_buffer: trigger-aware capture memory for the internal logic analyzer.
//
// Qualified samples are written into a circular buffer. After arm the buffer
// collects a programmable number of pre-trigger samples, waits for a trigger,
// stores post_count further samples and then freezes. The frozen window holds
// exactly DEPTH samples and is read back relative to the oldest sample.
//
// Optional feature (macro CAPTURE_TRIG_STAMP_EN): adds output trig_stamp, a
// saturating count of clocks spent in PREFILL/WAIT_TRIG since arm, frozen
// once the trigger is accepted.

module capture_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  sample_en,
    input  logic                  trigger,
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [2:0]            state,
    output logic                  done,
    output logic                  primed,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH-1:0] trig_offset
`ifdef CAPTURE_TRIG_STAMP_EN
    ,
    output logic [31:0]           trig_stamp
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // All-ones address: last physical location, and DEPTH-1 for the
    // pre/post split arithmetic (which naturally wraps at ADDR_WIDTH bits).
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREFILL   = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                cur_state;
    logic [ADDR_WIDTH-1:0] post_q;
    logic [ADDR_WIDTH-1:0] pre_cnt;
    logic [ADDR_WIDTH-1:0] post_cnt;
    logic                  capturing;
    logic                  wr_en;
    logic                  arm_ok;
    logic [ADDR_WIDTH-1:0] rd_phys;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    assign state = cur_state;

    // The buffer only accepts samples between arm and the end of the window;
    // IDLE and DONE never write, so a finished capture stays frozen.
    assign capturing = (cur_state == PREFILL) || (cur_state == WAIT_TRIG) ||
                       (cur_state == POST);
    assign wr_en     = capturing && sample_en;

    // arm is only honoured while no capture is in progress.
    assign arm_ok    = arm && ((cur_state == IDLE) || (cur_state == DONE));

    // Logical offset 0 is the oldest sample, which sits where the next write
    // would have gone; the sum wraps modulo DEPTH by its width.
    assign rd_phys   = waddr + rd_addr;

    // Sample storage; deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= i_data;
        end
    end

    // Capture sequencer: write pointer, priming flag, pre/post counters and
    // the window bookkeeping, all advanced only on qualified samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= IDLE;
            waddr       <= '0;
            primed      <= 1'b0;
            done        <= 1'b0;
            post_q      <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            trig_offset <= '0;
        end else begin
            if (wr_en) begin
                waddr <= waddr + ADDR_ONE;
                if (waddr == ADDR_MAX) begin
                    primed <= 1'b1;
                end
            end

            case (cur_state)
                IDLE, DONE: begin
                    if (arm) begin
                        waddr     <= '0;
                        primed    <= 1'b0;
                        done      <= 1'b0;
                        post_q    <= post_count;
                        pre_cnt   <= ADDR_MAX - post_count;
                        cur_state <= PREFILL;
                    end
                end

                PREFILL: begin
                    // A zero pre-trigger count moves on without needing a
                    // sample; otherwise the write that empties it does.
                    if (pre_cnt == '0) begin
                        cur_state <= WAIT_TRIG;
                    end else if (sample_en) begin
                        pre_cnt <= pre_cnt - ADDR_ONE;
                        if (pre_cnt == ADDR_ONE) begin
                            cur_state <= WAIT_TRIG;
                        end
                    end
                end

                WAIT_TRIG: begin
                    if (sample_en && trigger) begin
                        trig_offset <= ADDR_MAX - post_q;
                        if (post_q == '0) begin
                            cur_state <= DONE;
                            done      <= 1'b1;
                        end else begin
                            post_cnt  <= post_q;
                            cur_state <= POST;
                        end
                    end
                end

                POST: begin
                    if (sample_en) begin
                        post_cnt <= post_cnt - ADDR_ONE;
                        if (post_cnt == ADDR_ONE) begin
                            cur_state <= DONE;
                            done      <= 1'b1;
                        end
                    end
                end

                default: begin
                    cur_state <= IDLE;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // Registered readout; only a frozen window may be read, otherwise the
    // last result is held and the valid flag drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en && (cur_state == DONE)) begin
            rd_data  <= mem[rd_phys];
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

`ifdef CAPTURE_TRIG_STAMP_EN
    // Trigger latency counter: counts every clock in PREFILL and WAIT_TRIG,
    // including the clock on which the trigger is accepted, then holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_stamp <= '0;
        end else if (arm_ok) begin
            trig_stamp <= '0;
        end else if (((cur_state == PREFILL) || (cur_state == WAIT_TRIG)) &&
                     (trig_stamp != 32'hFFFF_FFFF)) begin
            trig_stamp <= trig_stamp + 32'd1;
        end
    end
`endif

endmodule
